branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
// - EX-stage consumer of the ALU flag outputs (N,Z,C,V) produced by the A-B compare for branches.
// - Resolves B-type conditions and jumps, drives PC redirect and D/E flushes.
// - Runs a one-cycle wrong-path shadow FSM and keeps branch statistics counters.
// - Sits between the ALU and the hazard unit / fetch PC mux.
// PARAMETERS
// - CNT_WIDTH  32  width of BranchCount/TakenCount
// - PHT_BITS   4   log2 of predictor table entries (used only with BRANCH_PRED_EN)
// PORTS
// - clk          in   1          clock; all state on rising edge
// - reset        in   1          asynchronous, active-low reset
// - ValidE       in   1          EX holds a real instruction
// - StallE       in   1          EX stage stalled this cycle
// - BranchE      in   1          EX instruction is B-type
// - JumpE        in   1          EX instruction is JAL/JALR
// - Funct3E      in   3          branch funct3
// - N,Z,C,V      in   1 each     ALU flags for A-B (C=1 means no borrow, i.e. A>=B unsigned)
// - PCE          in   32         PC of EX instruction
// - PCF          in   32         fetch PC (predictor lookup)
// - PredTakenE   in   1          prediction carried with EX instruction
// - PCSrcE       out  1          redirect fetch this cycle
// - RedirFallE   out  1          redirect to PCE+4 (predicted-taken, actually not-taken)
// - FlushD       out  1          squash D stage
// - FlushE       out  1          squash E stage next cycle
// - PredTakenF   out  1          prediction for PCF
// - BranchCount  out  CNT_WIDTH  evaluated branches
// - TakenCount   out  CNT_WIDTH  taken branches
// BEHAVIOUR
// - cond: 000 BEQ Z; 001 BNE !Z; 100 BLT N^V; 101 BGE !(N^V);
//   110 BLTU !C; 111 BGEU C; 010/011 -> not taken.
// - eval = ValidE & ~StallE & (state==RUN).
// - taken = eval & (JumpE | BranchE & cond).
// - FSM: RUN -(taken or redirect)-> SHADOW; SHADOW -(~StallE)-> RUN; stalled SHADOW holds.
// - In SHADOW the EX instruction is wrong-path:
//   - no redirect, no counting, no predictor update.
// - Redirect outputs are combinational, zero latency, same cycle as eval.
//   - PCSrcE = FlushD = FlushE = redirect.
// - Counters update on the next edge after eval:
//   - BranchCount += eval & BranchE; TakenCount += eval & BranchE & cond.
//   - JumpE does not count; counters wrap modulo 2^CNT_WIDTH silently.
// - BranchE & JumpE both high: treat as jump (taken, not counted).
// - Reset (any time, mid-shadow included):
//   - state=RUN, counters=0, PHT entries=01, all outputs 0 while reset low.
// CONFIGURATION
// - BRANCH_PRED_EN defined:
//   - 2^PHT_BITS x 2-bit saturating PHT; lookup index PCF[PHT_BITS+1:2], update index PCE[PHT_BITS+1:2].
//   - PredTakenF = PHT[idx][1], combinational.
//   - redirect = eval & (JumpE | BranchE & (cond != PredTakenE)).
//   - RedirFallE = redirect & BranchE & PredTakenE & ~cond.
//   - PHT update on eval&BranchE: increment if cond else decrement, saturating 00/11.
//   - Same-cycle read/write of one index returns the old value.
// - BRANCH_PRED_EN undefined:
//   - no PHT; redirect = taken; PredTakenF = 0; RedirFallE = 0; PredTakenE ignored.
// TESTING
// - Reset low mid-SHADOW -> all outputs 0; after release state RUN, counters 0.
// - BEQ Z=1 ValidE=1 -> PCSrcE=FlushD=FlushE=1 same cycle.
//   - next cycle BEQ Z=1 -> PCSrcE=0 (SHADOW); BranchCount=1, TakenCount=1.
// - Sweep Funct3E x all 16 NZCV combinations -> PCSrcE matches cond table.
//   - e.g. BLT N=1,V=0 taken; BLTU C=1 not taken; funct3 010 never taken.
// - StallE=1 with BNE Z=0 -> PCSrcE=0, counters unchanged.
//   - taken with StallE high next cycle -> SHADOW held until StallE low.
// - Preload counters to 2^CNT_WIDTH-1 via 2^CNT_WIDTH-1 taken branches (CNT_WIDTH=4) -> next taken wraps both to 0.
// - BRANCH_PRED_EN, PHT_BITS=4: BEQ at PCE=0x40 taken x3 -> PHT[0] 01->10->11->11.
//   - PredTakenF=1 at PCF=0x40; a not-taken with PredTakenE=1 -> PCSrcE=1, RedirFallE=1.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch/jump resolver with wrong-path shadow FSM and statistics
//
// Purpose:
//   Resolves B-type conditions from the ALU flags of A-B and resolves jumps.
//   Drives the fetch redirect and the D/E flushes combinationally in the same cycle.
//   For one cycle after a taken branch or a redirect, the EX instruction is on the
//   wrong path. The SHADOW state ignores that instruction and holds while EX is stalled.
//   Counts evaluated branches and taken branches. Both counters wrap silently.
//
// Optional feature:
//   BRANCH_PRED_EN - adds a 2^PHT_BITS-entry 2-bit saturating pattern history table.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ValidE, StallE        EX holds a real instruction / EX stalled this cycle
//   BranchE, JumpE        EX instruction is B-type / JAL-JALR
//   Funct3E               branch condition select
//   N, Z, C, V            ALU flags of A-B (C=1: no borrow)
//   PCE, PCF              EX PC (predictor update index) / fetch PC (predictor lookup)
//   PredTakenE            prediction carried with the EX instruction
//   PCSrcE                redirect fetch this cycle
//   RedirFallE            redirect goes to PCE+4 (predicted taken, resolved not taken)
//   FlushD, FlushE        squash D now / squash E on the next edge
//   PredTakenF            prediction for PCF
//   BranchCount           evaluated branches
//   TakenCount            taken branches
module branch_resolve_unit #(
  parameter int CNT_WIDTH = 32,
  parameter int PHT_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidE,
  input  logic                 StallE,
  input  logic                 BranchE,
  input  logic                 JumpE,
  input  logic [2:0]           Funct3E,
  input  logic                 N,
  input  logic                 Z,
  input  logic                 C,
  input  logic                 V,
  input  logic [31:0]          PCE,
  input  logic [31:0]          PCF,
  input  logic                 PredTakenE,
  output logic                 PCSrcE,
  output logic                 RedirFallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 PredTakenF,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] TakenCount
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;

  logic cond;
  logic eval;
  logic is_branch;
  logic taken;
  logic redirect;

  always_comb begin
    cond = 1'b0;
    case (Funct3E)
      3'b000:  cond = Z;
      3'b001:  cond = ~Z;
      3'b100:  cond = N ^ V;
      3'b101:  cond = ~(N ^ V);
      3'b110:  cond = ~C;
      3'b111:  cond = C;
      default: cond = 1'b0;
    endcase
  end

  // Gating with reset keeps every combinational output low while reset is held.
  assign eval      = reset & ValidE & ~StallE & (state_q == ST_RUN);
  // When BranchE and JumpE are both high, the instruction behaves as a jump.
  assign is_branch = BranchE & ~JumpE;
  assign taken     = eval & (JumpE | (is_branch & cond));

`ifdef BRANCH_PRED_EN
  localparam int PHT_ENTRIES = 1 << PHT_BITS;

  logic [PHT_ENTRIES-1:0][1:0] pht_q;
  logic [1:0]                  pht_entry_d;
  logic [PHT_BITS-1:0]         rd_idx;
  logic [PHT_BITS-1:0]         wr_idx;

  assign rd_idx     = PCF[PHT_BITS+1:2];
  assign wr_idx     = PCE[PHT_BITS+1:2];
  // A read and a write to the same index in one cycle return the pre-update entry.
  assign PredTakenF = pht_q[rd_idx][1];
  assign redirect   = eval & (JumpE | (is_branch & (cond != PredTakenE)));
  assign RedirFallE = redirect & is_branch & PredTakenE & ~cond;

  always_comb begin
    pht_entry_d = pht_q[wr_idx];
    if (cond && pht_q[wr_idx] != 2'b11) begin
      pht_entry_d = pht_q[wr_idx] + 2'b01;
    end else if (!cond && pht_q[wr_idx] != 2'b00) begin
      pht_entry_d = pht_q[wr_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pht_q <= {PHT_ENTRIES{2'b01}};
    end else if (eval & is_branch) begin
      pht_q[wr_idx] <= pht_entry_d;
    end
  end
`else
  assign PredTakenF = 1'b0;
  assign redirect   = taken;
  assign RedirFallE = 1'b0;
`endif

  // The prediction inputs are only partly used, or not used at all, depending on the build.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, PCF, PCE, PredTakenE};

  assign PCSrcE = redirect;
  assign FlushD = redirect;
  assign FlushE = redirect;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (taken | redirect) state_d = ST_SHADOW;
      ST_SHADOW: if (!StallE) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (eval & is_branch) begin
      branch_cnt_d = branch_cnt_q + CNT_ONE;
      if (cond) taken_cnt_d = taken_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign TakenCount  = taken_cnt_q;

endmodule
